// File: rtl/if_pc_gen.sv
// Fetch PC generator with tournament (local/global/chooser) branch prediction.
// Prediction combinational on pc, next pc registered 1 cycle; stall[0] holds pc, EX redirect overrides stall.
module if_pc_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [31:0] inst_i,
    input  logic        ex_branch_valid_i,
    input  logic [31:0] ex_branch_pc_i,
    input  logic        ex_branch_taken_i,
    input  logic        ex_mispredict_i,
    input  logic [31:0] ex_redirect_pc_i,
    output logic [31:0] inst_addr_o,
    output logic        ce_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        pre_take_or_not_o,
    output logic        pre_sel_o
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]      pc;
    logic             ce;
    logic [3:0]       ghr;
    logic [15:0][1:0] lbht;
    logic [15:0][1:0] gbht;
    logic [15:0][1:0] chooser;

    logic [3:0]  idx;
    logic [3:0]  g_idx;
    logic        is_branch;
    logic        is_jal;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic        pred_taken;
    logic        pred_sel;
    logic [31:0] target;
    logic [31:0] next_pc;

    logic [3:0]  u_idx;
    logic [3:0]  ug_idx;
    logic [1:0]  l_old;
    logic [1:0]  g_old;
    logic [1:0]  c_old;
    logic        l_ok;
    logic        g_ok;

    logic        unused_ok;
    assign unused_ok = ^{stall[5:1], ex_branch_pc_i[31:6], ex_branch_pc_i[1:0]};

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11)
            r = c + 2'b01;
        else if (!up && c != 2'b00)
            r = c - 2'b01;
        return r;
    endfunction

    assign idx       = pc[5:2];
    assign g_idx     = ghr ^ pc[5:2];
    assign is_branch = (inst_i[6:0] == OP_BRANCH);
    assign is_jal    = (inst_i[6:0] == OP_JAL);
    assign b_imm     = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign j_imm     = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_sel   = 1'b0;
        target     = pc + b_imm;
        if (ce) begin
            pred_sel = chooser[idx][1];
            if (is_branch) begin
                pred_taken = pred_sel ? gbht[g_idx][1] : lbht[idx][1];
            end else if (is_jal) begin
                pred_taken = 1'b1;
                pred_sel   = 1'b0;
                target     = pc + j_imm;
            end
        end
    end

    always_comb begin
        if (ex_mispredict_i)
            next_pc = ex_redirect_pc_i;
        else if (stall[0])
            next_pc = pc;
        else if (pred_taken)
            next_pc = target;
        else
            next_pc = pc + 32'd4;
    end

    // Training uses the ghr value from before this resolution's shift.
    assign u_idx  = ex_branch_pc_i[5:2];
    assign ug_idx = ghr ^ ex_branch_pc_i[5:2];
    assign l_old  = lbht[u_idx];
    assign g_old  = gbht[ug_idx];
    assign c_old  = chooser[u_idx];
    assign l_ok   = (l_old[1] == ex_branch_taken_i);
    assign g_ok   = (g_old[1] == ex_branch_taken_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= 32'h0000_0000;
            ce      <= 1'b0;
            ghr     <= 4'h0;
            lbht    <= {16{2'b01}};
            gbht    <= {16{2'b01}};
            chooser <= {16{2'b01}};
        end else if (!ce) begin
            ce <= 1'b1;
        end else begin
            pc <= next_pc;
            if (ex_branch_valid_i) begin
                lbht[u_idx]  <= sat_step(l_old, ex_branch_taken_i);
                gbht[ug_idx] <= sat_step(g_old, ex_branch_taken_i);
                if (l_ok != g_ok)
                    chooser[u_idx] <= sat_step(c_old, g_ok);
                ghr <= {ghr[2:0], ex_branch_taken_i};
            end
        end
    end

    assign inst_addr_o       = pc;
    assign if_pc_o           = pc;
    assign ce_o              = ce;
    assign if_inst_o         = ce ? inst_i : 32'h0;
    assign pre_take_or_not_o = pred_taken;
    assign pre_sel_o         = pred_sel;

endmodule

// File: tb/tb_if_pc_gen.sv
module tb_if_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [31:0] inst_i;
    logic        ex_branch_valid_i;
    logic [31:0] ex_branch_pc_i;
    logic        ex_branch_taken_i;
    logic        ex_mispredict_i;
    logic [31:0] ex_redirect_pc_i;
    logic [31:0] inst_addr_o;
    logic        ce_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        pre_take_or_not_o;
    logic        pre_sel_o;

    always #5 clk = ~clk;

    if_pc_gen dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .inst_i            (inst_i),
        .ex_branch_valid_i (ex_branch_valid_i),
        .ex_branch_pc_i    (ex_branch_pc_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .ex_mispredict_i   (ex_mispredict_i),
        .ex_redirect_pc_i  (ex_redirect_pc_i),
        .inst_addr_o       (inst_addr_o),
        .ce_o              (ce_o),
        .if_pc_o           (if_pc_o),
        .if_inst_o         (if_inst_o),
        .pre_take_or_not_o (pre_take_or_not_o),
        .pre_sel_o         (pre_sel_o)
    );

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL16 = 32'h0100_006F;  // jal x0, +16
    localparam logic [31:0] BEQ8  = 32'h0000_0463;  // beq x0, x0, +8

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers for counters, history and fetch state.
    logic [31:0] m_pc;
    bit          m_ce;
    int          m_ghr;
    int          m_l[16];
    int          m_g[16];
    int          m_c[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ce  = 1'b0;
        m_ghr = 0;
        for (int i = 0; i < 16; i++) begin
            m_l[i] = 1;
            m_g[i] = 1;
            m_c[i] = 1;
        end
    endtask

    function automatic int b_imm(input logic [31:0] w);
        int v;
        v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v = v - 4096;
        return v;
    endfunction

    function automatic int j_imm(input logic [31:0] w);
        int v;
        v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) v = v - (1 << 20);
        return v;
    endfunction

    function automatic int bump(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic m_update(input logic [31:0] bpc, input bit tk);
        int i;
        int gi;
        bit lok;
        bit gok;
        i   = int'(bpc[5:2]);
        gi  = m_ghr ^ i;
        lok = ((m_l[i] >= 2) == tk);
        gok = ((m_g[gi] >= 2) == tk);
        m_l[i]  = bump(m_l[i], tk);
        m_g[gi] = bump(m_g[gi], tk);
        if (gok && !lok) m_c[i] = bump(m_c[i], 1'b1);
        if (lok && !gok) m_c[i] = bump(m_c[i], 1'b0);
        m_ghr = ((m_ghr << 1) | int'(tk)) & 15;
    endtask

    // One cycle: compare all outputs against the model at negedge, then advance the model.
    task automatic step();
        int          idx;
        bit          e_take;
        bit          e_sel;
        logic [31:0] e_inst;
        logic [31:0] tgt;
        if (!rst) model_reset();
        @(negedge clk);
        if (!rst) model_reset();
        idx    = int'(m_pc[5:2]);
        e_take = 1'b0;
        e_sel  = 1'b0;
        e_inst = 32'h0;
        tgt    = m_pc + 32'd4;
        if (m_ce) begin
            e_inst = inst_i;
            e_sel  = (m_c[idx] >= 2);
            if (inst_i[6:0] == 7'h63) begin
                e_take = e_sel ? (m_g[m_ghr ^ idx] >= 2) : (m_l[idx] >= 2);
                if (e_take) tgt = m_pc + 32'(b_imm(inst_i));
            end else if (inst_i[6:0] == 7'h6F) begin
                e_take = 1'b1;
                e_sel  = 1'b0;
                tgt    = m_pc + 32'(j_imm(inst_i));
            end
        end
        chk("ce_o", ce_o, m_ce);
        chk("inst_addr_o", inst_addr_o, m_pc);
        chk("if_pc_o", if_pc_o, m_pc);
        chk("if_inst_o", if_inst_o, e_inst);
        chk("pre_take_or_not_o", pre_take_or_not_o, e_take);
        chk("pre_sel_o", pre_sel_o, e_sel);
        @(posedge clk);
        if (rst) begin
            if (!m_ce) begin
                m_ce = 1'b1;
            end else begin
                if (ex_mispredict_i) m_pc = ex_redirect_pc_i;
                else if (!stall[0]) m_pc = tgt;
                if (ex_branch_valid_i) m_update(ex_branch_pc_i, ex_branch_taken_i);
            end
        end
        #1;
    endtask

    task automatic drive(input logic s0, input logic [31:0] ins, input logic bv,
                         input logic [31:0] bpc, input logic tk, input logic mp,
                         input logic [31:0] rpc);
        stall             = {5'b0, s0};
        inst_i            = ins;
        ex_branch_valid_i = bv;
        ex_branch_pc_i    = bpc;
        ex_branch_taken_i = tk;
        ex_mispredict_i   = mp;
        ex_redirect_pc_i  = rpc;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b0;
        drive(1'b0, NOP, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        #2;
        chk("reset ce_o", ce_o, 1'b0);
        chk("reset if_pc_o", if_pc_o, 32'h0);
        chk("reset if_inst_o", if_inst_o, 32'h0);
        chk("reset pre_take", pre_take_or_not_o, 1'b0);
        chk("reset pre_sel", pre_sel_o, 1'b0);
        step();

        // Release: ce after one edge, then sequential fetch.
        rst = 1'b1;
        step();
        #2;
        chk("ce after release", ce_o, 1'b1);
        chk("first pc", if_pc_o, 32'h0);
        step();
        chk("seq pc 4", if_pc_o, 32'h4);
        step();
        chk("seq pc 8", if_pc_o, 32'h8);

        // JAL +16 at 0x20.
        drive(1'b0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
        step();
        drive(1'b0, JAL16, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("jal pc", if_pc_o, 32'h20);
        chk("jal pre_take", pre_take_or_not_o, 1'b1);
        chk("jal pre_sel", pre_sel_o, 1'b0);
        step();
        chk("jal target", if_pc_o, 32'h30);

        // BEQ at 0x40 trained taken while stalled there.
        drive(1'b0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        step();
        drive(1'b1, BEQ8, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
        #2;
        chk("beq before update", pre_take_or_not_o, 1'b0);
        step();
        #2;
        chk("beq after 1 update", pre_take_or_not_o, 1'b1);
        chk("beq stall hold", if_pc_o, 32'h40);
        step();
        ex_branch_valid_i = 1'b0;
        #2;
        chk("beq after 2 updates", pre_take_or_not_o, 1'b1);
        chk("beq uses local", pre_sel_o, 1'b0);
        chk("model lbht0 sat", m_l[0], 3);
        step();
        ex_branch_valid_i = 1'b1;
        step();
        chk("model lbht0 stays 3", m_l[0], 3);
        drive(1'b0, BEQ8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("beq 3rd still taken", pre_take_or_not_o, 1'b1);
        step();
        chk("beq target", if_pc_o, 32'h48);

        // Stall alone holds; redirect overrides stall.
        drive(1'b1, NOP, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall hold", if_pc_o, 32'h48);
        end
        drive(1'b1, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        step();
        chk("redirect over stall", if_pc_o, 32'h100);

        // Async reset mid-stream at 0x58.
        drive(1'b0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'h58);
        step();
        drive(1'b0, BEQ8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("pc before reset", if_pc_o, 32'h58);
        rst = 1'b0;
        #1;
        chk("mid reset pc", if_pc_o, 32'h0);
        chk("mid reset ce", ce_o, 1'b0);
        chk("mid reset inst", if_inst_o, 32'h0);
        step();
        rst = 1'b1;
        step();
        drive(1'b0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        step();
        drive(1'b1, BEQ8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("counters reset take", pre_take_or_not_o, 1'b0);
        chk("counters reset sel", pre_sel_o, 1'b0);

        // Alternating T/N drives the chooser toward global.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, BEQ8, 1'b1, 32'h40, (k % 2) == 0, 1'b0, 32'h0);
            step();
        end
        ex_branch_valid_i = 1'b0;
        #2;
        chk("alt chooser sel", pre_sel_o, 1'b1);
        chk("model chooser0", m_c[0], 3);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[6:0] = 7'h63;
                1: w[6:0] = 7'h6F;
                2: w[6:0] = 7'h67;
                default: w = NOP;
            endcase
            drive($urandom_range(0, 3) == 0, w, $urandom_range(0, 2) == 0, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                  $urandom & 32'hFFFF_FFFC);
            stall[5:1] = 5'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port stall  in  6  pipeline stall vector; bit 0 holds the PC.
REQ-004 SHALL have port inst_i  in  32  instruction read combinationally at inst_addr_o.
REQ-005 SHALL have port ex_branch_valid_i  in  1  conditional branch resolved in EX this cycle.
REQ-006 SHALL have port ex_branch_pc_i  in  32  PC of the resolved branch.
REQ-007 SHALL have port ex_branch_taken_i  in  1  actual branch direction.
REQ-008 SHALL have port ex_mispredict_i  in  1  redirect request, covering direction miss and JALR.
REQ-009 SHALL have port ex_redirect_pc_i  in  32  correct next PC on redirect.
REQ-010 SHALL have port inst_addr_o  out  32  fetch address, equal to the PC register.
REQ-011 SHALL have port ce_o  out  1  instruction memory enable.
REQ-012 SHALL have port if_pc_o  out  32  PC to the IF/ID register.
REQ-013 SHALL have port if_inst_o  out  32  instruction to IF/ID; 0 when ce_o=0.
REQ-014 SHALL have port pre_take_or_not_o  out  1  predicted-taken flag for the current fetch.
REQ-015 SHALL have port pre_sel_o  out  1  predictor used: 0 local, 1 global.

Function
REQ-016 SHALL hold three 16-entry tables of 2-bit saturating counters: LBHT indexed pc[5:2], GBHT indexed ghr[3:0]^pc[5:2], CHOOSER indexed pc[5:2].
REQ-017 SHALL hold a 4-bit non-speculative global history ghr, shifted left with ex_branch_taken_i inserted at bit 0 on each ex_branch_valid_i.
REQ-018 SHALL decode inst_i combinationally: B-type (opcode 1100011), JAL (1101111), other.
REQ-019 SHALL set pre_sel_o=CHOOSER[pc[5:2]][1] and, for B-type, pre_take_or_not_o=bit 1 of the selected counter.
REQ-020 SHALL predict JAL as taken (pre_take_or_not_o=1, pre_sel_o=0); all other instructions, JALR included, not taken (pre_take_or_not_o=0).
REQ-021 SHALL compute the taken target as pc + sign-extended B or J immediate, modulo 2^32.
REQ-022 SHALL select next PC in priority order: ex_mispredict_i -> ex_redirect_pc_i; stall[0]=1 -> hold; predicted taken -> target; else pc+4 (wraps at 2^32).
REQ-023 SHALL let ex_mispredict_i override stall[0].
REQ-024 SHALL, on ex_branch_valid_i, update LBHT[ex_branch_pc_i[5:2]] and GBHT[ghr^ex_branch_pc_i[5:2]] toward ex_branch_taken_i (+1 taken, -1 not taken), saturating at 0 and 3, using the ghr value from before the shift.
REQ-025 SHALL, on the same event, increment CHOOSER when only global was correct, decrement it when only local was correct, else leave it unchanged; direction = bit 1 of the pre-update counter; saturating.
REQ-026 SHALL, when predict and update hit the same entry in one cycle, predict from the pre-update value; the update takes effect next cycle.
REQ-027 SHALL drive ce_o=0 while rst=0 and set it to 1 on the first clk edge after release; PC, tables and ghr SHALL not change while ce_o=0.
REQ-028 SHALL hold all predictor state unchanged during stall[0] except updates from ex_branch_valid_i.
REQ-029 SHALL have a prediction latency of 0 cycles (combinational on the current PC) and a next-PC latency of 1 cycle.

Reset
REQ-030 SHALL, asynchronously on rst=0, set pc=0x0000_0000, ce_o=0, ghr=0, and every LBHT, GBHT and CHOOSER entry to 2'b01.
REQ-031 SHALL keep if_inst_o=0, pre_take_or_not_o=0 and pre_sel_o=0 during reset.
REQ-032 SHALL abandon any in-flight prediction or redirect when reset is asserted mid-operation; after release, fetch restarts at 0x0.

Verification
REQ-033 SHALL pass: reset release, stall=0, NOP stream -> ce_o=1 after 1 edge, if_pc_o = 0x0, 0x4, 0x8 ... on successive cycles.
REQ-034 SHALL pass: JAL imm=+16 fetched at PC 0x20 -> pre_take_or_not_o=1, next if_pc_o=0x30.
REQ-035 SHALL pass: BEQ at 0x40 resolved taken 2 times -> LBHT[0] saturates 01->10->11, next fetch predicts taken; a 3rd taken update leaves it at 11.
REQ-036 SHALL pass: stall[0]=1 with ex_mispredict_i=1, ex_redirect_pc_i=0x100 -> next if_pc_o=0x100; stall alone holds the PC for N cycles.
REQ-037 SHALL pass: rst pulsed low mid-stream at PC 0x58 -> immediately if_pc_o=0x0, ce_o=0, all counters 01.
REQ-038 SHALL pass: alternating T/N pattern at one branch for 16 resolutions -> CHOOSER entry reaches >=10 and pre_sel_o=1.
